// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time and reads the
// rows back. Every full scan of four columns is one frame. Each frame is
// classified as no key, exactly one key, or several keys. A debounce FSM
// turns a run of identical frames into a single press event. The event is
// delivered as a 4-bit key code (row_index*4 + col_index) on a valid/ready
// handshake.
//
// Handshake (key_valid / key_ready):
//   key_valid rises when a press is accepted and key_code holds that code.
//   Both stay stable until the consumer takes the event, which happens in
//   any cycle where key_valid and key_ready are both high. key_valid drops
//   in the following cycle unless a new press is accepted in that same
//   handshake cycle, in which case the new code is loaded and key_valid
//   stays high. A press accepted while an older event is still pending is
//   dropped, and key_ovf pulses for one cycle.
//
// fsm_state exposes the debounce state: 0 idle, 1 candidate, 2 pressed,
// 3 release.

module keypad_scanner #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       key_ovf,
    output logic [1:0] fsm_state
);

    // Dwell counter width. SCAN_DIV is at least 4, so DW is at least 2.
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // The frame counter must be able to hold DEB_FRAMES itself.
    localparam int CW = $clog2(DEB_FRAMES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEB_FRAMES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAND    = 2'd1,
        S_PRESSED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    // Two-flop synchronizer. It resets to all-released so that no phantom
    // closure can be seen straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column scan
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          dwell_end;
    logic          frame_end;

    assign dwell_end = (dwell == DWELL_LAST);
    assign frame_end = dwell_end && (col_idx == 2'd3);

    // Each column is driven for SCAN_DIV cycles, then the scan rotates
    // to the next column. The column index wraps naturally 3 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (dwell_end) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    // Exactly one column is low. It is decoded straight from the index,
    // so col can never show zero or two active columns.
    assign col = ~(4'b0001 << col_idx);

    // ------------------------------------------------------------------
    // Per-column sample and frame accumulation
    // ------------------------------------------------------------------
    logic [2:0] samp_n;     // closures seen in the current column
    logic [1:0] samp_row;   // row of a closure in this column
    logic [1:0] acc_n;      // closures so far this frame, saturating at 2
    logic [3:0] acc_code;   // code of the first closure this frame
    logic [2:0] sum_n;
    logic [1:0] merged_n;   // frame total, including the current column
    logic [3:0] merged_code;
    logic       is_none;
    logic       is_one;

    // Count the closed rows in the current column and remember the row
    // of one of them. Only the row of a lone closure is ever used.
    always_comb begin
        samp_n   = 3'd0;
        samp_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                samp_n   = samp_n + 3'd1;
                samp_row = 2'(r);
            end
        end
    end

    // Fold the current column's sample into the frame running totals.
    // At the last column this gives the full-frame classification.
    always_comb begin
        sum_n       = 3'(acc_n) + samp_n;
        merged_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        merged_code = (acc_n == 2'd0) ? {samp_row, col_idx} : acc_code;
        is_none     = (merged_n == 2'd0);
        is_one      = (merged_n == 2'd1);
    end

    // Accumulate closures over the frame. Clear at the frame end so the
    // next frame starts from nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
        end else if (dwell_end) begin
            if (col_idx == 2'd3) begin
                acc_n    <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_n    <= merged_n;
                acc_code <= merged_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand;
    logic [3:0]    cand_nxt;

    assign cnt_inc   = cnt + CNT_ONE;
    assign fsm_state = state;

    // State register: debounce state, matching-frame count and candidate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    // Next state: decisions are taken only at frame end, using the
    // classification of the frame that has just finished.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (is_one) begin
                        cand_nxt = merged_code;
                        if (DEB_FRAMES == 1) begin
                            state_nxt = S_PRESSED;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_CAND;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                S_CAND: begin
                    if (is_one && (merged_code == cand)) begin
                        if (cnt_inc == CNT_TARGET) begin
                            state_nxt = S_PRESSED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt   = cnt_inc;
                        end
                    end else if (is_one) begin
                        // A different single key restarts the run.
                        cand_nxt = merged_code;
                        cnt_nxt  = CNT_ONE;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                S_PRESSED: begin
                    // Extra or changed keys are ignored while held down.
                    if (is_none) begin
                        if (DEB_FRAMES == 1) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_RELEASE;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (is_none) begin
                        if (cnt_inc == CNT_TARGET) begin
                            state_nxt = S_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt   = cnt_inc;
                        end
                    end else begin
                        // Bounce during release: back to held, no new event.
                        state_nxt = S_PRESSED;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    logic accept;
    logic release_done;
    logic handshake;

    // Decode the press-accepted and release-completed strobes from the
    // state transition taken at this frame end.
    always_comb begin
        accept       = frame_end && (state_nxt == S_PRESSED) &&
                       ((state == S_IDLE) || (state == S_CAND));
        release_done = frame_end && (state_nxt == S_IDLE) &&
                       ((state == S_RELEASE) || (state == S_PRESSED));
        handshake    = key_valid && key_ready;
    end

    // Event register: load a new code when the slot is free or is being
    // emptied this cycle. Otherwise drop the press and flag the overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            key_ovf   <= 1'b0;
        end else begin
            key_ovf <= 1'b0;
            if (accept) begin
                key_down <= 1'b1;
                if (!key_valid || handshake) begin
                    key_code  <= merged_code;
                    key_valid <= 1'b1;
                end else begin
                    key_ovf   <= 1'b1;
                end
            end else if (handshake) begin
                key_valid <= 1'b0;
            end
            if (release_done) begin
                key_down <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4 and DEB_FRAMES=3 (16-cycle frames).
// A keypad model turns a 16-bit "keys held" mask into row levels for the
// column being driven. A frame-level reference model predicts the outputs
// every cycle. A frame table with hand-derived expectations walks the
// directed cases, a mid-debounce reset sequence follows, and then random
// frames are applied.

module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SD;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       key_ovf;
    logic [1:0] fsm_state;

    keypad_scanner #(.SCAN_DIV(SD), .DEB_FRAMES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .key_ovf   (key_ovf),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad model ----------------
    logic [15:0] keys;
    logic [15:0] keys_next;
    logic        ready_next;

    // A held key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys[r*4+c]) row[r] = 1'b0;
    end

    // ---------------- bookkeeping ----------------
    int total;
    int bad;
    int cyc;

    logic [3:0] exp_q[$];
    int         hist[$];

    logic       m_valid;
    logic [3:0] m_code;
    logic       m_down;
    logic       m_ovf;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_col(input int c);
        logic [3:0] one;
        one = 4'b0001 << ((c / SD) % 4);
        return ~one;
    endfunction

    // -1 = no key, 0..15 = exactly one key, 16 = several keys.
    function automatic int classify(input logic [15:0] k);
        int n;
        int code;
        n = 0;
        code = 0;
        for (int i = 0; i < 16; i++)
            if (k[i]) begin
                n++;
                code = i;
            end
        if (n == 0) return -1;
        if (n == 1) return code;
        return 16;
    endfunction

    // True when the last DEB frames in the history all equal want.
    function automatic bit last_frames_are(input int want);
        if (hist.size() < DEB) return 1'b0;
        for (int k = 0; k < DEB; k++)
            if (hist[hist.size()-1-k] != want) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_code  = 4'd0;
        m_down  = 1'b0;
        m_ovf   = 1'b0;
        hist.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    // One clock cycle. Called at a negedge: check outputs, drive the next
    // inputs, advance the model, then move to the next negedge.
    task automatic tick();
        int   cls;
        bit   acc;
        bit   hs_m;
        logic [3:0] acode;
        check("cycle", {5'd0, col, key_valid, key_code, key_down, key_ovf},
              {5'd0, exp_col(cyc), m_valid, m_code, m_down, m_ovf});
        if (cyc % FRAME == 0) keys = keys_next;
        key_ready = ready_next;
        if (key_valid && key_ready) begin
            if (exp_q.size() == 0) check("sb_extra_event", 16'(key_code), 16'hFFFF);
            else check("sb_code", 16'(key_code), 16'(exp_q.pop_front()));
        end
        hs_m  = m_valid && key_ready;
        m_ovf = 1'b0;
        acc   = 1'b0;
        acode = 4'd0;
        if (cyc % FRAME == FRAME - 1) begin
            cls = classify(keys);
            hist.push_back(cls);
            if (!m_down) begin
                if (cls >= 0 && cls < 16 && last_frames_are(cls)) begin
                    acc    = 1'b1;
                    acode  = 4'(cls);
                    m_down = 1'b1;
                    hist.delete();
                end
            end else if (last_frames_are(-1)) begin
                m_down = 1'b0;
                hist.delete();
            end
        end
        if (acc) begin
            if (!m_valid || hs_m) begin
                m_valid = 1'b1;
                m_code  = acode;
                exp_q.push_back(acode);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (hs_m) begin
            m_valid = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [15:0] k, input logic rdy);
        keys_next  = k;
        ready_next = rdy;
        repeat (FRAME) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col"},   16'(col), 16'h000E);
        check({tag, "_valid"}, 16'(key_valid), 16'h0);
        check({tag, "_code"},  16'(key_code), 16'h0);
        check({tag, "_down"},  16'(key_down), 16'h0);
        check({tag, "_ovf"},   16'(key_ovf), 16'h0);
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        logic [15:0] keys;
        logic        ready;
        logic        exp_down;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] k, input logic rdy, input logic d,
                       input logic v, input logic [3:0] c, input logic o);
        vec_t e;
        e.keys = k; e.ready = rdy; e.exp_down = d;
        e.exp_valid = v; e.exp_code = c; e.exp_ovf = o;
        vecs.push_back(e);
    endtask

    function automatic logic [15:0] kbit(input int n);
        logic [15:0] one;
        one = 16'd1;
        return one << n;
    endfunction

    // ---------------- main ----------------
    initial begin
        int early;
        logic [15:0] prev;
        int a;
        int b;
        int r;

        total = 0;
        bad   = 0;
        keys = 16'h0; keys_next = 16'h0;
        key_ready = 1'b0; ready_next = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // Expectations are sampled in the cycle right after each frame end.
        for (int i = 0; i < 5; i++) add(16'h0, 1, 0, 0, 4'd0, 0);      // idle
        add(kbit(9), 1, 0, 0, 4'd0, 0);                                // key 9
        add(kbit(9), 1, 0, 0, 4'd0, 0);
        add(kbit(9), 1, 1, 1, 4'd9, 0);
        add(kbit(9), 1, 1, 0, 4'd0, 0);
        add(kbit(9), 1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 0, 0, 4'd0, 0);
        add(kbit(5), 1, 0, 0, 4'd0, 0);                                // bounce
        add(16'h0,   1, 0, 0, 4'd0, 0);
        add(kbit(5), 1, 0, 0, 4'd0, 0);
        add(16'h0,   1, 0, 0, 4'd0, 0);
        for (int i = 0; i < 6; i++) add(kbit(0) | kbit(15), 1, 0, 0, 4'd0, 0);
        add(kbit(0), 1, 0, 0, 4'd0, 0);
        add(kbit(0), 1, 0, 0, 4'd0, 0);
        add(kbit(0), 1, 1, 1, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 0, 0, 4'd0, 0);
        add(kbit(3), 0, 0, 0, 4'd0, 0);                                // backpressure
        add(kbit(3), 0, 0, 0, 4'd0, 0);
        add(kbit(3), 0, 1, 1, 4'd3, 0);
        add(16'h0,   0, 1, 1, 4'd3, 0);
        add(16'h0,   0, 1, 1, 4'd3, 0);
        add(16'h0,   0, 0, 1, 4'd3, 0);
        add(kbit(7), 0, 0, 1, 4'd3, 0);
        add(kbit(7), 0, 0, 1, 4'd3, 0);
        add(kbit(7), 0, 1, 1, 4'd3, 1);                                // dropped
        add(kbit(7), 1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 1, 0, 4'd0, 0);
        add(16'h0,   1, 0, 0, 4'd0, 0);

        // Reset: 3 cycles low, released at a negedge (this is cycle 0).
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_values("rst");

        for (int i = 0; i < vecs.size(); i++) begin
            run_frame(vecs[i].keys, vecs[i].ready);
            check($sformatf("vec%0d_down", i),  16'(key_down),  16'(vecs[i].exp_down));
            check($sformatf("vec%0d_valid", i), 16'(key_valid), 16'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovf", i),   16'(key_ovf),   16'(vecs[i].exp_ovf));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_code", i), 16'(key_code), 16'(vecs[i].exp_code));
        end

        // Pending event, then reset during candidate with two matching frames.
        repeat (3) run_frame(kbit(9), 1'b0);
        check("pend_valid", 16'(key_valid), 16'h1);
        check("pend_code",  16'(key_code),  16'h9);
        repeat (3) run_frame(16'h0, 1'b0);
        check("pend_released", 16'(key_down), 16'h0);
        repeat (2) run_frame(kbit(6), 1'b0);
        keys_next = kbit(6);
        repeat (5) tick();
        check("pre_rst_valid", 16'(key_valid), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_values("midrst");
        keys_next  = kbit(6);
        ready_next = 1'b1;
        early = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (key_valid) early++;
            tick();
        end
        check("midrst_no_early_event", 16'(early), 16'h0);
        check("midrst_event_valid", 16'(key_valid), 16'h1);
        check("midrst_event_code",  16'(key_code),  16'h6);

        // Random frames: sticky key masks so runs long enough to debounce occur.
        prev = 16'h0;
        for (int f = 0; f < 150; f++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                keys_next = prev;
            end else if (r < 6) begin
                keys_next = 16'h0;
            end else if (r < 9) begin
                keys_next = kbit($urandom_range(0, 15));
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                keys_next = kbit(a) | kbit(b);
            end
            prev = keys_next;
            for (int c = 0; c < FRAME; c++) begin
                ready_next = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        // Drain: release everything and accept whatever is pending.
        repeat (4) run_frame(16'h0, 1'b1);
        check("drain_queue_empty", 16'(exp_q.size()), 16'h0);
        check("drain_down", 16'(key_down), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
